// File: rtl/bisr_pkg.sv
// Shared types and width helpers for the BISR spare allocator.
// Pure declarations; no logic, no latency, no flow control.
package bisr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_ISSUE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic int col_w(input int num_cols);
        return $clog2(num_cols);
    endfunction

    function automatic int spare_w(input int num_spares);
        return $clog2(num_spares);
    endfunction

endpackage

// File: rtl/priority_encoder.sv
// Returns the lowest index whose bit equals ENCODED_VAL (0 when none match).
// Purely combinational; no flow control.
module priority_encoder #(
    parameter int WIDTH       = 8,
    parameter bit ENCODED_VAL = 1'b1,
    parameter int IDX_W       = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] vec_i,
    output logic [IDX_W-1:0] idx_o
);

    // Scan from the top so the lowest matching index is written last and wins.
    always_comb begin
        idx_o = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (vec_i[i] == ENCODED_VAL) begin
                idx_o = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/bisr_spare_allocator.sv
// Maps BIST-reported faulty columns to spare columns, lowest fault to lowest free spare.
// Latency: bist_done at T -> first remap_vld at T+2, then 2 cycles per accepted entry.
// Backpressure: remap entry held stable until remap_rdy; BISR_REPAIR_COUNT_EN adds repair_count.
module bisr_spare_allocator
    import bisr_pkg::*;
#(
    parameter int  NUM_COLS   = 8,
    parameter int  NUM_SPARES = 2,
    localparam int COL_W      = col_w(NUM_COLS),
    localparam int SPARE_W    = spare_w(NUM_SPARES)
`ifdef BISR_REPAIR_COUNT_EN
    ,
    localparam int COUNT_W    = $clog2(NUM_SPARES + 1)
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               fault_vld,
    input  logic [COL_W-1:0]   fault_col,
    input  logic               bist_done,
    input  logic               clear,
    input  logic               remap_rdy,
    output logic               remap_vld,
    output logic [COL_W-1:0]   remap_col,
    output logic [SPARE_W-1:0] remap_spare,
    output logic               busy,
    output logic               repair_done,
    output logic               repair_fail
`ifdef BISR_REPAIR_COUNT_EN
    ,
    output logic [COUNT_W-1:0] repair_count
`endif
);

    localparam logic [COL_W:0] COL_LIM = (COL_W + 1)'(NUM_COLS);

    state_t                  state_q, state_d;
    logic [NUM_COLS-1:0]     fault_map_q, fault_map_d;
    logic [NUM_SPARES-1:0]   spare_used_q, spare_used_d;
    logic [COL_W-1:0]        remap_col_q, remap_col_d;
    logic [SPARE_W-1:0]      remap_spare_q, remap_spare_d;
    logic                    done_q, done_d;
    logic                    fail_q, fail_d;

    logic [COL_W-1:0]        low_fault;
    logic [SPARE_W-1:0]      low_free;
    logic                    any_fault;
    logic                    all_used;
    logic                    accept;

    priority_encoder #(
        .WIDTH       (NUM_COLS),
        .ENCODED_VAL (1'b1),
        .IDX_W       (COL_W)
    ) u_fault_enc (
        .vec_i (fault_map_q),
        .idx_o (low_fault)
    );

    priority_encoder #(
        .WIDTH       (NUM_SPARES),
        .ENCODED_VAL (1'b0),
        .IDX_W       (SPARE_W)
    ) u_spare_enc (
        .vec_i (spare_used_q),
        .idx_o (low_free)
    );

    assign any_fault = |fault_map_q;
    assign all_used  = &spare_used_q;
    assign accept    = (state_q == ST_ISSUE) && remap_rdy;

    always_comb begin
        state_d       = state_q;
        fault_map_d   = fault_map_q;
        spare_used_d  = spare_used_q;
        remap_col_d   = remap_col_q;
        remap_spare_d = remap_spare_q;
        done_d        = done_q;
        fail_d        = fail_q;

        // clear overrides everything, including an entry being accepted this cycle.
        if (clear) begin
            state_d       = ST_IDLE;
            fault_map_d   = '0;
            spare_used_d  = '0;
            remap_col_d   = '0;
            remap_spare_d = '0;
            done_d        = 1'b0;
            fail_d        = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (fault_vld && ({1'b0, fault_col} < COL_LIM)) begin
                        fault_map_d[fault_col] = 1'b1;
                    end
                    if (bist_done) begin
                        state_d = ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (!any_fault) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else if (all_used) begin
                        state_d = ST_DONE;
                        fail_d  = 1'b1;
                    end else begin
                        remap_col_d   = low_fault;
                        remap_spare_d = low_free;
                        state_d       = ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (remap_rdy) begin
                        fault_map_d[remap_col_q]    = 1'b0;
                        spare_used_d[remap_spare_q] = 1'b1;
                        state_d                     = ST_SCAN;
                    end
                end
                default: begin
                    state_d = ST_DONE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            fault_map_q   <= '0;
            spare_used_q  <= '0;
            remap_col_q   <= '0;
            remap_spare_q <= '0;
            done_q        <= 1'b0;
            fail_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            fault_map_q   <= fault_map_d;
            spare_used_q  <= spare_used_d;
            remap_col_q   <= remap_col_d;
            remap_spare_q <= remap_spare_d;
            done_q        <= done_d;
            fail_q        <= fail_d;
        end
    end

    assign remap_vld   = (state_q == ST_ISSUE);
    assign busy        = (state_q == ST_SCAN) || (state_q == ST_ISSUE);
    assign remap_col   = remap_col_q;
    assign remap_spare = remap_spare_q;
    assign repair_done = done_q;
    assign repair_fail = fail_q;

`ifdef BISR_REPAIR_COUNT_EN
    logic [COUNT_W-1:0] count_q;

    // At most NUM_SPARES entries are accepted between clears, so no wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (accept) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign repair_count = count_q;
`else
    logic unused_accept;
    assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_bisr_spare_allocator.sv
// Self-checking bench for bisr_spare_allocator: vector table plus corner-case sequences.
module tb_bisr_spare_allocator;
    import bisr_pkg::*;

    localparam int NC = 7;
    localparam int NS = 2;
    localparam int CW = 3;
    localparam int SW = 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          fault_vld = 1'b0;
    logic [CW-1:0] fault_col = '0;
    logic          bist_done = 1'b0;
    logic          clear = 1'b0;
    logic          remap_rdy = 1'b1;
    logic          remap_vld;
    logic [CW-1:0] remap_col;
    logic [SW-1:0] remap_spare;
    logic          busy;
    logic          repair_done;
    logic          repair_fail;
`ifdef BISR_REPAIR_COUNT_EN
    logic [1:0]    repair_count;
`endif

    bisr_spare_allocator #(
        .NUM_COLS   (NC),
        .NUM_SPARES (NS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .fault_vld    (fault_vld),
        .fault_col    (fault_col),
        .bist_done    (bist_done),
        .clear        (clear),
        .remap_rdy    (remap_rdy),
        .remap_vld    (remap_vld),
        .remap_col    (remap_col),
        .remap_spare  (remap_spare),
        .busy         (busy),
        .repair_done  (repair_done),
        .repair_fail  (repair_fail)
`ifdef BISR_REPAIR_COUNT_EN
        ,
        .repair_count (repair_count)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int col;
        int spare;
        int cyc;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    typedef struct {
        logic [6:0] mask;
        int         n_remap;
        logic       exp_done;
        logic       exp_fail;
    } vec_t;
    vec_t vt[8];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (remap_vld && remap_rdy) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_remap: col %0d spare %0d at cycle %0d",
                             remap_col, remap_spare, cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("remap_col", int'(remap_col), mon_e.col);
                    chk("remap_spare", int'(remap_spare), mon_e.spare);
                    chk("remap_cycle", cyc, mon_e.cyc);
                end
            end
            chk("done_fail_exclusive", int'(repair_done & repair_fail), 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic report(input int c);
        fault_vld = 1'b1;
        fault_col = c[CW-1:0];
        tick();
        fault_vld = 1'b0;
    endtask

    task automatic start(output int t);
        bist_done = 1'b1;
        t = cyc;
        tick();
        bist_done = 1'b0;
        fault_vld = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic push(input int c, input int s, input int t);
        exp_t e;
        e.col = c;
        e.spare = s;
        e.cyc = t;
        exp_q.push_back(e);
    endtask

    task automatic wait_status(output int td);
        td = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (repair_done || repair_fail) begin
                td = cyc;
                break;
            end
        end
        if (td < 0) begin
            checks++;
            errors++;
            $display("FAIL status_timeout: no repair status within 60 cycles (cycle %0d)", cyc);
        end
    endtask

    initial begin
        int t;
        int td;
        int k;
        int low;
        logic [6:0] rem;

        vt[0] = '{7'h00, 0, 1'b1, 1'b0};
        vt[1] = '{7'h24, 2, 1'b1, 1'b0};
        vt[2] = '{7'h4A, 2, 1'b0, 1'b1};
        vt[3] = '{7'h01, 1, 1'b1, 1'b0};
        vt[4] = '{7'h40, 1, 1'b1, 1'b0};
        vt[5] = '{7'h7F, 2, 1'b0, 1'b1};
        vt[6] = '{7'h03, 2, 1'b1, 1'b0};
        vt[7] = '{7'h50, 2, 1'b1, 1'b0};

        // Reset state
        #2;
        chk("rst_vld", int'(remap_vld), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(repair_done), 0);
        chk("rst_fail", int'(repair_fail), 0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("rst_state", int'(dut.state_q), int'(ST_IDLE));

        // Table: report high bits first, lowest fault together with bist_done.
        for (int v = 0; v < 8; v++) begin
            do_clear();
            remap_rdy = 1'b1;
            low = -1;
            for (int b = 0; b < NC; b++) begin
                if (vt[v].mask[b] && low < 0) low = b;
            end
            for (int b = NC - 1; b >= 0; b--) begin
                if (vt[v].mask[b] && b != low) report(b);
            end
            if (low >= 0) begin
                fault_vld = 1'b1;
                fault_col = low[CW-1:0];
            end
            t = cyc;
            k = 0;
            rem = vt[v].mask;
            for (int b = 0; b < NC; b++) begin
                if (vt[v].mask[b] && k < NS) begin
                    push(b, k, t + 2 + 2 * k);
                    rem[b] = 1'b0;
                    k++;
                end
            end
            start(t);
            wait_status(td);
            chk("vec_done", int'(repair_done), int'(vt[v].exp_done));
            chk("vec_fail", int'(repair_fail), int'(vt[v].exp_fail));
            chk("vec_status_cycle", td, t + 2 + 2 * vt[v].n_remap);
            chk("vec_queue_empty", exp_q.size(), 0);
            chk("vec_busy", int'(busy), 0);
            if (vt[v].exp_fail) chk("vec_fault_map_left", int'(dut.fault_map_q), int'(rem));
`ifdef BISR_REPAIR_COUNT_EN
            chk("vec_count", int'(repair_count), vt[v].n_remap);
`endif
            tick();
        end

        // DONE ignores new faults and bist_done
        fault_vld = 1'b1;
        fault_col = 3'd3;
        bist_done = 1'b1;
        tick();
        fault_vld = 1'b0;
        bist_done = 1'b0;
        tick();
        tick();
        chk("done_hold", int'(repair_done), 1);
        chk("done_not_busy", int'(busy), 0);
        chk("done_map_untouched", int'(dut.fault_map_q), 0);

        // Asynchronous reset out of DONE
        #3 rst = 1'b1;
        #1 chk("arst_done", int'(repair_done), 0);
        tick();
        rst = 1'b0;
        tick();
        chk("arst_state", int'(dut.state_q), int'(ST_IDLE));

        // Asynchronous reset while an entry is being offered
        report(3);
        remap_rdy = 1'b0;
        start(t);
        tick();
        chk("arst_issue_vld_before", int'(remap_vld), 1);
        #2 rst = 1'b1;
        #1 chk("arst_issue_vld", int'(remap_vld), 0);
        chk("arst_issue_busy", int'(busy), 0);
        chk("arst_issue_col", int'(remap_col), 0);
        tick();
        rst = 1'b0;
        tick();

        // Backpressure: hold three cycles, accept on the fourth
        report(3);
        report(1);
        remap_rdy = 1'b0;
        start(t);
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("bp_vld", int'(remap_vld), 1);
            chk("bp_col", int'(remap_col), 1);
            chk("bp_spare", int'(remap_spare), 0);
            tick();
        end
        push(1, 0, t + 5);
        push(3, 1, t + 7);
        remap_rdy = 1'b1;
        wait_status(td);
        chk("bp_done", int'(repair_done), 1);
        chk("bp_status_cycle", td, t + 9);
        chk("bp_queue_empty", exp_q.size(), 0);
        tick();

        // clear during ISSUE drops the entry; spare 0 is free again afterwards
        do_clear();
        report(2);
        remap_rdy = 1'b0;
        start(t);
        tick();
        chk("clr_vld_before", int'(remap_vld), 1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr_vld", int'(remap_vld), 0);
        chk("clr_busy", int'(busy), 0);
        chk("clr_spares", int'(dut.spare_used_q), 0);
        chk("clr_map", int'(dut.fault_map_q), 0);
        fault_vld = 1'b1;
        fault_col = 3'd0;
        remap_rdy = 1'b1;
        push(0, 0, cyc + 2);
        start(t);
        wait_status(td);
        chk("clr_done", int'(repair_done), 1);
        chk("clr_status_cycle", td, t + 4);
        chk("clr_queue_empty", exp_q.size(), 0);
        tick();

        // Out-of-range index and duplicate report
        do_clear();
        report(7);
        report(4);
        report(4);
        chk("edge_map", int'(dut.fault_map_q), 16);
        push(4, 0, cyc + 2);
        start(t);
        wait_status(td);
        chk("edge_done", int'(repair_done), 1);
        chk("edge_status_cycle", td, t + 4);
        chk("edge_queue_empty", exp_q.size(), 0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
